// File: rtl/pipe_control_param.sv
// Pipeline controller for the 8-bit-instruction processor, depth STAGES.
// Tracks per-stage valid bits and drives the stage enables and IR loads.
// Also inserts load-use bubbles, selects bypass producers for the read
// stage, flushes younger stages on a taken branch and drains cleanly on stop.
// Optional macro PIPE_PERF_CNT_EN adds the cycle and retired-instruction
// counters. Without it both counter outputs are tied to zero.
//
// Fetch FSM:
//   state        | meaning
//   FETCH_RUN    | fetch active, stage 0 receives a new instruction each edge
//   FETCH_FROZEN | stop fetched, pipeline draining toward writeback
//   FETCH_HALTED | stop retired, all enables off until reset

module pipe_control_param #(
  parameter int STAGES   = 4,
  parameter int BR_STAGE = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [8*STAGES-1:0]   ir_all,
  input  logic                  N,
  input  logic                  Z,
  output logic [STAGES-1:0]     en,
  output logic [STAGES-1:0]     ir_load,
  output logic                  branch,
  output logic                  stall,
  output logic [STAGES-1:0]     bypass_r1,
  output logic [STAGES-1:0]     bypass_r2,
  output logic                  halted,
  output logic [31:0]           cyc_count,
  output logic [31:0]           ret_count
);

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STOP  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_SHIFT = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_BZ    = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_ORI   = 4'd7;
  localparam logic [3:0] OP_NAND  = 4'd8;
  localparam logic [3:0] OP_BNZ   = 4'd9;
  localparam logic [3:0] OP_NOP   = 4'd10;
  localparam logic [3:0] OP_BPZ   = 4'd13;

  typedef enum logic [1:0] {
    FETCH_RUN,
    FETCH_FROZEN,
    FETCH_HALTED
  } fetch_state_t;

  fetch_state_t        state, state_nxt;
  logic [STAGES-1:0]   valid, valid_nxt;
  logic [7:0]          ir [STAGES];
  logic                stall_raw;
  logic                flush_stop;
  logic [3:0]          op_br;

  // shift and ori carry immediate bits in ir[3], so only the low three bits name them
  function automatic logic [3:0] opcode(input logic [7:0] i);
    if (i[2:0] == 3'd3 || i[2:0] == 3'd7) return {1'b0, i[2:0]};
    return i[3:0];
  endfunction

  function automatic logic is_writer(input logic [7:0] i);
    return opcode(i) inside {OP_ADD, OP_SUB, OP_NAND, OP_LOAD, OP_SHIFT, OP_ORI};
  endfunction

  function automatic logic [1:0] dest_reg(input logic [7:0] i);
    return (opcode(i) == OP_ORI) ? 2'd1 : i[7:6];
  endfunction

  function automatic logic reads_r1(input logic [7:0] i);
    return opcode(i) inside {OP_ADD, OP_SUB, OP_NAND, OP_STORE, OP_SHIFT, OP_ORI};
  endfunction

  function automatic logic reads_r2(input logic [7:0] i);
    return opcode(i) inside {OP_ADD, OP_SUB, OP_NAND, OP_STORE};
  endfunction

  function automatic logic [1:0] src_r1(input logic [7:0] i);
    return (opcode(i) == OP_ORI) ? 2'd1 : i[7:6];
  endfunction

  // split the flat IR bus into per-stage bytes
  always_comb begin
    for (int k = 0; k < STAGES; k++) ir[k] = ir_all[8*k +: 8];
  end

  // branch resolution, load-use detection and stop-flush detection
  always_comb begin
    op_br  = opcode(ir[BR_STAGE]);
    branch = valid[BR_STAGE] &&
             ((op_br == OP_BZ  &&  Z) ||
              (op_br == OP_BNZ && !Z) ||
              (op_br == OP_BPZ && !N));
    stall_raw = valid[2] && (opcode(ir[2]) == OP_LOAD) && valid[1] &&
                ((reads_r1(ir[1]) && src_r1(ir[1]) == ir[2][7:6]) ||
                 (reads_r2(ir[1]) && ir[1][5:4]    == ir[2][7:6]));
    stall = stall_raw && !branch;
    flush_stop = 1'b0;
    for (int k = 1; k < BR_STAGE; k++) begin
      if (valid[k] && opcode(ir[k]) == OP_STOP) flush_stop = 1'b1;
    end
  end

  // youngest valid producer wins; a load still in execute has no data yet
  always_comb begin
    bypass_r1 = '0;
    bypass_r2 = '0;
    if (valid[1]) begin
      for (int k = STAGES - 1; k >= 2; k--) begin
        if (valid[k] && is_writer(ir[k]) && !(k == 2 && opcode(ir[k]) == OP_LOAD)) begin
          if (reads_r1(ir[1]) && dest_reg(ir[k]) == src_r1(ir[1])) begin
            bypass_r1    = '0;
            bypass_r1[k] = 1'b1;
          end
          if (reads_r2(ir[1]) && dest_reg(ir[k]) == ir[1][5:4]) begin
            bypass_r2    = '0;
            bypass_r2[k] = 1'b1;
          end
        end
      end
    end
  end

  // fetch FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_RUN:
        if (valid[0] && opcode(ir[0]) == OP_STOP && !stall) state_nxt = FETCH_FROZEN;
      FETCH_FROZEN:
        if (valid[STAGES-1] && opcode(ir[STAGES-1]) == OP_STOP) state_nxt = FETCH_HALTED;
        else if (branch && flush_stop)                          state_nxt = FETCH_RUN;
      FETCH_HALTED:
        state_nxt = FETCH_HALTED;
      default:
        state_nxt = FETCH_RUN;
    endcase
  end

  // valid-bit advance: shift, with hold/bubble on stall and flush on branch
  always_comb begin
    valid_nxt    = {valid[STAGES-2:0], 1'b0};
    valid_nxt[0] = (state_nxt == FETCH_RUN);
    if (stall) begin
      valid_nxt[1:0] = valid[1:0];
      valid_nxt[2]   = 1'b0;
    end
    if (branch) begin
      for (int k = 1; k <= BR_STAGE; k++) valid_nxt[k] = 1'b0;
    end
  end

  // state and valid registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FETCH_RUN;
      valid <= '0;
    end else begin
      state <= state_nxt;
      valid <= valid_nxt;
    end
  end

  // stage enables; reset gates them so they drop without a clock edge
  always_comb begin
    en    = valid;
    en[0] = (state == FETCH_RUN);
    if (stall) en[1:0] = 2'b00;
    if (reset || state == FETCH_HALTED) en = '0;
    ir_load = en;
    halted  = (state == FETCH_HALTED);
  end

`ifdef PIPE_PERF_CNT_EN
  // performance counters: cycles until halt, non-nop retirements
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_count <= '0;
      ret_count <= '0;
    end else begin
      if (state != FETCH_HALTED) cyc_count <= cyc_count + 32'd1;
      if (valid[STAGES-1] && opcode(ir[STAGES-1]) != OP_NOP) ret_count <= ret_count + 32'd1;
    end
  end
`else
  assign cyc_count = '0;
  assign ret_count = '0;
`endif

endmodule

// File: tb/tb_pipe_control_param.sv
// Self-checking bench for pipe_control_param (4-stage main instance plus a
// 6-stage instance for the deep bypass case).
module tb_pipe_control_param;

  localparam logic [7:0] NOP  = 8'h0A;
  localparam logic [7:0] STOP = 8'h01;
  localparam logic [7:0] BZ   = 8'h05;
  localparam logic [7:0] BNZ  = 8'h09;
  localparam logic [7:0] BPZ  = 8'h0D;

  localparam int K_LOAD = 0, K_STOP = 1, K_STORE = 2, K_SHIFT = 3, K_ADD = 4;
  localparam int K_BZ = 5, K_SUB = 6, K_ORI = 7, K_NAND = 8, K_BNZ = 9;
  localparam int K_NOP = 10, K_BPZ = 13;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ir_all;
  logic        N = 1'b0, Z = 1'b0;
  logic [3:0]  en, ir_load, bypass_r1, bypass_r2;
  logic        branch, stall, halted;
  logic [31:0] cyc_count, ret_count;

  logic [47:0] ir6;
  logic [5:0]  en6, ir_load6, byp6_r1, byp6_r2;
  logic        branch6, stall6, halted6;
  logic [31:0] cyc6, ret6;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  pipe_control_param #(.STAGES(4), .BR_STAGE(2)) dut (
    .clock(clock), .reset(reset), .ir_all(ir_all), .N(N), .Z(Z),
    .en(en), .ir_load(ir_load), .branch(branch), .stall(stall),
    .bypass_r1(bypass_r1), .bypass_r2(bypass_r2), .halted(halted),
    .cyc_count(cyc_count), .ret_count(ret_count)
  );

  pipe_control_param #(.STAGES(6), .BR_STAGE(3)) dut6 (
    .clock(clock), .reset(reset), .ir_all(ir6), .N(N), .Z(Z),
    .en(en6), .ir_load(ir_load6), .branch(branch6), .stall(stall6),
    .bypass_r1(byp6_r1), .bypass_r2(byp6_r2), .halted(halted6),
    .cyc_count(cyc6), .ret_count(ret6)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (4 stages, branch at 2) ----------------
  typedef struct packed {
    logic [3:0] en;
    logic       br;
    logic       st;
    logic [3:0] b1;
    logic [3:0] b2;
    logic [3:0] occ_n;
    logic       fetch_n;
    logic       halt_n;
  } pred_t;

  function automatic int kind(input logic [7:0] i);
    if (i[2:0] == 3'd3) return K_SHIFT;
    if (i[2:0] == 3'd7) return K_ORI;
    return int'(i[3:0]);
  endfunction

  function automatic pred_t predict(input logic [3:0] occ, input logic fetch_on,
                                    input logic halt, input logic [31:0] irs,
                                    input logic n, input logic z);
    pred_t      p;
    int         kd [4];
    logic [1:0] r1f [4];
    logic [1:0] r2f [4];
    logic [1:0] want [2];
    logic       has [2];
    logic [1:0] dst;
    logic       stopping, revive;
    p = '0;
    for (int k = 0; k < 4; k++) begin
      kd[k]  = kind(irs[8*k +: 8]);
      r1f[k] = irs[8*k+6 +: 2];
      r2f[k] = irs[8*k+4 +: 2];
    end
    p.br = occ[2] && ((kd[2] == K_BZ && z) || (kd[2] == K_BNZ && !z) || (kd[2] == K_BPZ && !n));
    has[0]  = occ[1] && (kd[1] inside {K_ADD, K_SUB, K_NAND, K_STORE, K_SHIFT, K_ORI});
    want[0] = (kd[1] == K_ORI) ? 2'd1 : r1f[1];
    has[1]  = occ[1] && (kd[1] inside {K_ADD, K_SUB, K_NAND, K_STORE});
    want[1] = r2f[1];
    p.st = occ[2] && kd[2] == K_LOAD &&
           ((has[0] && want[0] == r1f[2]) || (has[1] && want[1] == r1f[2])) && !p.br;
    // scan oldest first so the youngest matching producer overwrites
    for (int k = 3; k >= 2; k--) begin
      if (occ[k] && (kd[k] inside {K_ADD, K_SUB, K_NAND, K_LOAD, K_SHIFT, K_ORI}) &&
          !(k == 2 && kd[k] == K_LOAD)) begin
        dst = (kd[k] == K_ORI) ? 2'd1 : r1f[k];
        if (has[0] && dst == want[0]) begin p.b1 = '0; p.b1[k] = 1'b1; end
        if (has[1] && dst == want[1]) begin p.b2 = '0; p.b2[k] = 1'b1; end
      end
    end
    if (!halt) begin
      p.en    = occ;
      p.en[0] = fetch_on;
      if (p.st) p.en[1:0] = 2'b00;
    end
    stopping  = occ[0] && kd[0] == K_STOP && !p.st;
    revive    = p.br && occ[1] && kd[1] == K_STOP;
    p.halt_n  = halt || (occ[3] && kd[3] == K_STOP);
    p.fetch_n = !p.halt_n && ((fetch_on && !stopping) || revive);
    if (p.st) p.occ_n = {occ[2], 1'b0, occ[1], occ[0]};
    else      p.occ_n = {occ[2:0], p.fetch_n};
    if (p.br) p.occ_n[2:1] = 2'b00;
    return p;
  endfunction

  logic [3:0] m_occ;
  logic       m_fetch, m_halt;
  int         m_cyc, m_ret;
  pred_t      p_now;

  assign p_now = predict(m_occ, m_fetch, m_halt, ir_all, N, Z);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_occ <= '0; m_fetch <= 1'b1; m_halt <= 1'b0; m_cyc <= 0; m_ret <= 0;
    end else begin
      m_occ   <= p_now.occ_n;
      m_fetch <= p_now.fetch_n;
      m_halt  <= p_now.halt_n;
      if (!m_halt) m_cyc <= m_cyc + 1;
      if (m_occ[3] && kind(ir_all[31:24]) != K_NOP) m_ret <= m_ret + 1;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clock) begin
    logic [3:0] e_en;
    logic [31:0] e_cyc, e_ret;
    e_en = reset ? 4'b0 : p_now.en;
`ifdef PIPE_PERF_CNT_EN
    e_cyc = 32'(m_cyc);
    e_ret = 32'(m_ret);
`else
    e_cyc = 32'd0;
    e_ret = 32'd0;
`endif
    chk("m_en",      32'(en),        32'(e_en));
    chk("m_ir_load", 32'(ir_load),   32'(e_en));
    chk("m_branch",  32'(branch),    32'(p_now.br));
    chk("m_stall",   32'(stall),     32'(p_now.st));
    chk("m_byp_r1",  32'(bypass_r1), 32'(p_now.b1));
    chk("m_byp_r2",  32'(bypass_r2), 32'(p_now.b2));
    chk("m_halted",  32'(halted),    32'(m_halt));
    chk("m_cyc",     cyc_count,      e_cyc);
    chk("m_ret",     ret_count,      e_ret);
  end

  // one cycle of stimulus: change inputs just after the edge, settle to mid-cycle
  task automatic drive(input logic [31:0] v, input logic z, input logic n);
    @(posedge clock);
    #1;
    ir_all = v; Z = z; N = n;
    @(negedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] fill [5];
    fill[0] = 4'b0001; fill[1] = 4'b0011; fill[2] = 4'b0111;
    fill[3] = 4'b1111; fill[4] = 4'b1111;
    ir_all = {4{NOP}};
    ir6    = {8'hB6, NOP, 8'h94, NOP, 8'h84, NOP};
    #1 reset = 1'b1;
    #2;
    chk("rst_en",     32'(en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall",  32'(stall), 32'd0);
    @(negedge clock); @(negedge clock);
    #2 reset = 1'b0;
    #1 chk("fill_release", 32'(en), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      chk("fill_en", 32'(en), 32'(fill[i]));
    end

    // bypass selection
    drive({8'h64, NOP, 8'h94, NOP}, 1'b0, 1'b0);
    chk("byp_wb_r1", 32'(bypass_r1), 32'b0000);
    chk("byp_wb_r2", 32'(bypass_r2), 32'b1000);
    drive({8'h64, 8'h76, 8'h07, NOP}, 1'b0, 1'b0);
    chk("byp_ori_r1", 32'(bypass_r1), 32'b0100);
    chk("byp_ori_r2", 32'(bypass_r2), 32'b0000);
    drive({8'h64, 8'h76, NOP, NOP}, 1'b0, 1'b0);
    chk("byp_noread", 32'(bypass_r1), 32'b0000);
    chk("deep_en",  32'(en6),     32'b111111);
    chk("deep_byp", 32'(byp6_r1), 32'b001000);
    chk("deep_r2",  32'(byp6_r2), 32'b000000);

    // load-use stall
    drive({8'h14, 8'h00, 8'h34, NOP}, 1'b0, 1'b0);
    chk("stall_on",   32'(stall),     32'd1);
    chk("stall_en",   32'(en),        32'b1100);
    chk("stall_byp",  32'(bypass_r1), 32'b1000);
    drive({4{NOP}}, 1'b0, 1'b0);
    chk("stall_once", 32'(stall), 32'd0);
    chk("bubble_ex",  32'(en),    32'b1011);
    drive({4{NOP}}, 1'b0, 1'b0);
    chk("bubble_wb",  32'(en),    32'b0111);
    drive({4{NOP}}, 1'b0, 1'b0);

    // branches
    drive({NOP, BZ, NOP, NOP}, 1'b1, 1'b0);
    chk("bz_taken", 32'(branch), 32'd1);
    drive({4{NOP}}, 1'b0, 1'b0);
    chk("bz_flush_en", 32'(en), 32'b1001);
    repeat (2) drive({4{NOP}}, 1'b0, 1'b0);
    drive({NOP, BZ, NOP, NOP}, 1'b0, 1'b0);
    chk("bz_not", 32'(branch), 32'd0);
    drive({NOP, BNZ, NOP, NOP}, 1'b0, 1'b0);
    chk("bnz_taken", 32'(branch), 32'd1);
    repeat (3) drive({4{NOP}}, 1'b0, 1'b0);
    drive({NOP, BPZ, NOP, NOP}, 1'b0, 1'b1);
    chk("bpz_neg", 32'(branch), 32'd0);
    drive({NOP, BPZ, NOP, NOP}, 1'b0, 1'b0);
    chk("bpz_taken", 32'(branch), 32'd1);
    repeat (3) drive({4{NOP}}, 1'b0, 1'b0);

    // stop and drain
    drive({NOP, NOP, NOP, STOP}, 1'b0, 1'b0);
    chk("stop_fetch_en", 32'(en), 32'b1111);
    drive({NOP, NOP, STOP, NOP}, 1'b0, 1'b0);
    chk("stop_freeze", 32'(en), 32'b1110);
    drive({NOP, STOP, NOP, NOP}, 1'b0, 1'b0);
    drive({STOP, NOP, NOP, NOP}, 1'b0, 1'b0);
    chk("stop_wb_en",  32'(en),     32'b1000);
    chk("stop_not_yet", 32'(halted), 32'd0);
    drive({4{NOP}}, 1'b0, 1'b0);
    chk("halted", 32'(halted), 32'd1);
    chk("halt_en", 32'(en), 32'd0);
    repeat (2) drive({4{NOP}}, 1'b0, 1'b0);
    chk("halt_sticky", 32'(halted), 32'd1);

    // reset clears halt, then reset in the middle of a stall
    #1 reset = 1'b1;
    #1 chk("rst_clr_halt", 32'(halted), 32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (4) drive({4{NOP}}, 1'b0, 1'b0);
    drive({8'h14, 8'h00, 8'h34, NOP}, 1'b0, 1'b0);
    chk("pre_rst_stall", 32'(stall), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_stall", 32'(stall),     32'd0);
    chk("async_byp",   32'(bypass_r1), 32'd0);
    chk("async_en",    32'(en),        32'd0);
    chk("async_ld",    32'(ir_load),   32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    ir_all = {4{NOP}};
    repeat (2) drive({4{NOP}}, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
